// File: rtl/servo_pwm_drive.sv
// Servo angle resolver and PWM driver: alpha = asin(LUTin) - atan via an external
// synchronous ROM, clamped, then turned into a frame-aligned hobby-servo pulse.
//
// state  | meaning
// IDLE   | waiting for a sample; issues the ROM address when one is present
// LOOKUP | ROM is registering rom_addr
// SUM    | rom_data valid; commit angle, saturation and next pulse width
module servo_pwm_drive #(
    parameter int PERIOD       = 2000000,
    parameter int CENTER       = 150000,
    parameter int CYC_PER_UNIT = 55,
    parameter int ANG_MAX      = 900,
    parameter int ANG_MIN      = -900
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               validIn,
    input  logic signed [16:0] LUTin,
    input  logic signed [12:0] atan,
    output logic               ready,
    output logic [9:0]         rom_addr,
    input  logic signed [12:0] rom_data,
    output logic signed [12:0] angle,
    output logic               angle_valid,
    output logic               saturated,
    output logic               pwm,
    output logic               period_start
);

    typedef enum logic [1:0] {IDLE, LOOKUP, SUM} state_t;

    localparam logic [20:0]        LAST_COUNT = 21'(PERIOD - 1);
    localparam logic signed [21:0] CENTER_W   = 22'(CENTER);
    localparam logic signed [21:0] CPU_W      = 22'(CYC_PER_UNIT);
    localparam logic signed [13:0] AMAX_W     = 14'(ANG_MAX);
    localparam logic signed [13:0] AMIN_W     = 14'(ANG_MIN);

    state_t             state;
    logic               pending;
    logic signed [16:0] lut_q;
    logic signed [12:0] atan_q;
    logic signed [12:0] work_atan;
    logic               work_clip;
    logic signed [21:0] pulse_next;
    logic signed [21:0] pulse_active;
    logic [20:0]        count;

    logic signed [16:0] lut_sel;
    logic signed [12:0] atan_sel;
    logic signed [15:0] lut_clamped;
    logic               lut_clip;
    logic [15:0]        lut_biased;
    logic signed [13:0] alpha_raw;
    logic signed [13:0] alpha_clamp;
    logic               alpha_clip;
    logic signed [21:0] pulse_calc;

    // A sample arriving in the same cycle as the lookup starts is the newest one.
    always_comb begin
        lut_sel  = validIn ? LUTin : lut_q;
        atan_sel = validIn ? atan  : atan_q;
        lut_clip = 1'b0;
        if (lut_sel > 17'sd32767) begin
            lut_clamped = 16'sh7fff;
            lut_clip    = 1'b1;
        end else if (lut_sel < -17'sd32768) begin
            lut_clamped = 16'sh8000;
            lut_clip    = 1'b1;
        end else begin
            lut_clamped = lut_sel[15:0];
        end
        lut_biased = {~lut_clamped[15], lut_clamped[14:0]};
    end

    always_comb begin
        alpha_raw  = {rom_data[12], rom_data} - {work_atan[12], work_atan};
        alpha_clip = 1'b0;
        if (alpha_raw > AMAX_W) begin
            alpha_clamp = AMAX_W;
            alpha_clip  = 1'b1;
        end else if (alpha_raw < AMIN_W) begin
            alpha_clamp = AMIN_W;
            alpha_clip  = 1'b1;
        end else begin
            alpha_clamp = alpha_raw;
        end
        pulse_calc = CENTER_W + 22'(alpha_clamp) * CPU_W;
    end

    assign ready = (state == IDLE) && !pending;

    // SUM always drops back through IDLE, so a continuous stream settles at one
    // result every three cycles and IDLE picks up whatever arrived meanwhile.
    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            pending     <= 1'b0;
            lut_q       <= '0;
            atan_q      <= '0;
            work_atan   <= '0;
            work_clip   <= 1'b0;
            rom_addr    <= '0;
            angle       <= '0;
            angle_valid <= 1'b0;
            saturated   <= 1'b0;
            pulse_next  <= CENTER_W;
        end else begin
            angle_valid <= 1'b0;
            if (validIn) begin
                lut_q   <= LUTin;
                atan_q  <= atan;
                pending <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (pending || validIn) begin
                        pending   <= 1'b0;
                        rom_addr  <= 10'(lut_biased >> 6);
                        work_atan <= atan_sel;
                        work_clip <= lut_clip;
                        state     <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    state <= SUM;
                end
                SUM: begin
                    angle       <= alpha_clamp[12:0];
                    saturated   <= work_clip | alpha_clip;
                    angle_valid <= 1'b1;
                    pulse_next  <= pulse_calc;
                    state       <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Width is only ever swapped at the frame boundary to keep the pulse glitch-free.
    always_ff @(posedge clock) begin
        if (reset) begin
            count        <= '0;
            pulse_active <= CENTER_W;
            period_start <= 1'b0;
            pwm          <= 1'b0;
        end else begin
            pwm <= $signed({1'b0, count}) < pulse_active;
            if (count == LAST_COUNT) begin
                count        <= '0;
                pulse_active <= pulse_next;
                period_start <= 1'b1;
            end else begin
                count        <= count + 21'd1;
                period_start <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_servo_pwm_drive.sv
// Directed bench for servo_pwm_drive with a linear ROM model (data = addr - 512)
// and a short PWM frame so whole frames can be measured.
module tb_servo_pwm_drive;

    logic               clock = 1'b0;
    logic               reset;
    logic               validIn;
    logic signed [16:0] LUTin;
    logic signed [12:0] atan;
    logic               ready;
    logic [9:0]         rom_addr;
    logic signed [12:0] rom_data;
    logic signed [12:0] angle;
    logic               angle_valid;
    logic               saturated;
    logic               pwm;
    logic               period_start;

    int vectors = 0;
    int miscompares = 0;
    int flen;
    int fhigh;

    servo_pwm_drive #(
        .PERIOD(2000), .CENTER(150), .CYC_PER_UNIT(1), .ANG_MAX(900), .ANG_MIN(-900)
    ) dut (
        .clock(clock), .reset(reset), .validIn(validIn), .LUTin(LUTin), .atan(atan),
        .ready(ready), .rom_addr(rom_addr), .rom_data(rom_data), .angle(angle),
        .angle_valid(angle_valid), .saturated(saturated), .pwm(pwm),
        .period_start(period_start)
    );

    always #5 clock = ~clock;

    always @(posedge clock) rom_data <= $signed({3'b000, rom_addr}) - 13'sd512;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic sample(input logic signed [16:0] l, input logic signed [12:0] a,
                          input int ea, input int eang, input int esat);
        validIn = 1'b1; LUTin = l; atan = a;
        tick();
        validIn = 1'b0;
        chk("rom_addr", rom_addr, ea);
        chk("ready_busy1", ready, 0);
        chk("av_early1", angle_valid, 0);
        tick();
        chk("ready_busy2", ready, 0);
        chk("av_early2", angle_valid, 0);
        tick();
        chk("av_pulse", angle_valid, 1);
        chk("angle", angle, eang);
        chk("saturated", saturated, esat);
        chk("ready_back", ready, 1);
        tick();
        chk("av_single", angle_valid, 0);
    endtask

    // Entered in a count==0 cycle; returns in the next period_start cycle.
    task automatic run_frame(input int inj, input logic signed [12:0] a,
                             output int len, output int high);
        int k;
        k = 0;
        high = 0;
        for (int i = 0; i < 2100; i++) begin
            high += int'(pwm);
            validIn = (k == inj);
            LUTin = '0;
            atan = a;
            tick();
            k++;
            if (period_start) break;
        end
        validIn = 1'b0;
        len = k;
    endtask

    initial begin
        reset = 1'b1; validIn = 1'b0; LUTin = '0; atan = '0;
        tick(); tick(); tick();
        chk("rst_ready", ready, 1);
        chk("rst_angle", angle, 0);
        chk("rst_av", angle_valid, 0);
        chk("rst_sat", saturated, 0);
        chk("rst_pwm", pwm, 0);
        chk("rst_ps", period_start, 0);
        chk("rst_addr", rom_addr, 0);
        reset = 1'b0;
        tick(); tick();

        // basic lookups, then LUTin and alpha clamps at both ends
        sample(17'sd0, 13'sd0, 512, 0, 0);
        sample(17'sd16384, -13'sd100, 768, 356, 0);
        sample(17'sd40000, -13'sd500, 1023, 900, 1);
        sample(-17'sd65536, 13'sd0, 0, -512, 1);
        sample(17'sd0, 13'sd950, 512, -900, 1);
        sample(17'sd32767, -13'sd389, 1023, 900, 0);

        // three back-to-back samples: the middle one is overwritten
        validIn = 1'b1; LUTin = 17'sd0; atan = 13'sd0;
        tick();
        LUTin = 17'sd64;
        tick();
        LUTin = 17'sd128;
        tick();
        validIn = 1'b0;
        chk("b2b_av_n3", angle_valid, 1);
        chk("b2b_angle_n3", angle, 0);
        tick();
        chk("b2b_av_n4", angle_valid, 0);
        tick();
        chk("b2b_av_n5", angle_valid, 0);
        tick();
        chk("b2b_av_n6", angle_valid, 1);
        chk("b2b_angle_n6", angle, 2);
        tick();
        chk("b2b_av_n7", angle_valid, 0);
        tick();
        chk("b2b_av_n8", angle_valid, 0);
        tick();
        chk("b2b_av_n9", angle_valid, 0);

        // restore a 150-clock width, then align to a frame boundary
        sample(17'sd0, 13'sd0, 512, 0, 0);
        for (int i = 0; i < 2100; i++) begin
            if (period_start) break;
            tick();
        end
        chk("sync_ps", period_start, 1);
        run_frame(-1, 13'sd0, flen, fhigh);
        chk("f0_len", flen, 2000);
        chk("f0_high", fhigh, 150);

        // commit angle 100 mid-frame: effective one frame later
        run_frame(497, -13'sd100, flen, fhigh);
        chk("f1_len", flen, 2000);
        chk("f1_high", fhigh, 150);
        chk("f1_angle", angle, 100);
        run_frame(-1, 13'sd0, flen, fhigh);
        chk("f2_len", flen, 2000);
        chk("f2_high", fhigh, 250);

        // commit angle -50 on the same edge as the frame load: old width survives one more frame
        run_frame(1997, 13'sd50, flen, fhigh);
        chk("f3_len", flen, 2000);
        chk("f3_high", fhigh, 250);
        chk("f3_angle", angle, -50);
        run_frame(-1, 13'sd0, flen, fhigh);
        chk("f4_high", fhigh, 250);
        run_frame(-1, 13'sd0, flen, fhigh);
        chk("f5_high", fhigh, 100);

        // reset during LOOKUP with another sample pending
        tick();
        validIn = 1'b1; LUTin = 17'sd16384; atan = -13'sd100;
        tick();
        LUTin = 17'sd0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        validIn = 1'b0;
        chk("mr_angle", angle, 0);
        chk("mr_ready", ready, 1);
        chk("mr_av", angle_valid, 0);
        chk("mr_pwm_low", pwm, 0);
        chk("mr_addr", rom_addr, 0);
        run_frame(-1, 13'sd0, flen, fhigh);
        chk("mr_len", flen, 2000);
        chk("mr_high", fhigh, 150);
        chk("mr_angle_after", angle, 0);
        chk("mr_ready_after", ready, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Any angle_valid after the mid-operation reset would be a stale result.
    always @(negedge clock) begin
        if (reset === 1'b1 && vectors > 7) begin
            #2;
            for (int i = 0; i < 6; i++) begin
                @(negedge clock);
                if (angle_valid !== 1'b0) begin
                    miscompares++;
                    $error("FAIL mr_no_av observed=%0d expected=0", angle_valid);
                end
            end
        end
    end

endmodule
